// File: rtl/xbar_slot_ctrl.sv
// xbar_slot_ctrl: per-slot sequencer that locks scheduler grants to egresses and drives dequeue/crossbar control
module xbar_slot_ctrl #(
  parameter int SLOT_CYCLES = 16,
  parameter int LEN_W       = 8,
  parameter int TIMEOUT     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  output logic             sched_en,
  input  logic             sched_done,
  input  logic [3:0]       sched_grant,
  input  logic [7:0]       sched_sel,
  output logic [3:0]       is_busy,
  output logic [7:0]       busy_voq_num,
  input  logic [4*LEN_W-1:0] pkt_len,
  output logic [3:0]       deq_start,
  output logic [3:0]       deq_word,
  output logic [7:0]       xbar_sel,
  output logic [3:0]       xbar_vld,
  output logic             timeout_err,
  output logic             conflict_err
);
  localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  typedef enum logic [2:0] {IDLE, SCHED, WAIT, LOAD, XFER} state_t;
  state_t state, nxt;
  logic [SW-1:0] slot_cnt;
  logic [TW-1:0] wait_cnt;
  logic [LEN_W-1:0] rem [4];
  logic [3:0] newl, gnew, held;
  logic gconf, slot_last, wait_last;
  assign slot_last = slot_cnt == SW'(SLOT_CYCLES - 1);
  assign wait_last = wait_cnt == TW'(TIMEOUT - 1);
  assign sched_en  = state == SCHED;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // next-state: enable is only looked at when a slot ends
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = enable ? SCHED : IDLE;
      SCHED: nxt = WAIT;
      WAIT:  nxt = (sched_done || wait_last) ? LOAD : WAIT;
      LOAD:  nxt = XFER;
      XFER:  nxt = slot_last ? (enable ? SCHED : IDLE) : XFER;
      default: nxt = IDLE;
    endcase
  end
  // grant filter: in ingress order, drop grants whose egress is already held or newly claimed
  always_comb begin
    held  = '0;
    gnew  = '0;
    gconf = 1'b0;
    for (int i = 0; i < 4; i++)
      if (is_busy[i]) held[busy_voq_num[2*i+:2]] = 1'b1;
    for (int i = 0; i < 4; i++)
      if (sched_grant[i] && !is_busy[i]) begin
        if (held[sched_sel[2*i+:2]]) gconf = 1'b1;
        else begin
          gnew[i] = 1'b1;
          held[sched_sel[2*i+:2]] = 1'b1;
        end
      end
  end
  // locks, remaining lengths, slot/wait counters and sticky errors
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      is_busy      <= '0;
      busy_voq_num <= '0;
      newl         <= '0;
      slot_cnt     <= '0;
      wait_cnt     <= '0;
      timeout_err  <= 1'b0;
      conflict_err <= 1'b0;
      for (int i = 0; i < 4; i++) rem[i] <= '0;
    end else begin
      case (state)
        SCHED: begin
          wait_cnt <= '0;
          newl     <= '0;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (sched_done) begin
            is_busy <= is_busy | gnew;
            newl    <= gnew;
            if (gconf) conflict_err <= 1'b1;
            for (int i = 0; i < 4; i++)
              if (gnew[i]) busy_voq_num[2*i+:2] <= sched_sel[2*i+:2];
          end else if (wait_last) timeout_err <= 1'b1;
        end
        LOAD: begin
          newl     <= '0;
          slot_cnt <= '0;
          for (int i = 0; i < 4; i++)
            if (newl[i]) begin
              rem[i] <= pkt_len[i*LEN_W+:LEN_W];
              if (pkt_len[i*LEN_W+:LEN_W] == '0) is_busy[i] <= 1'b0;
            end
        end
        XFER: begin
          slot_cnt <= slot_last ? '0 : slot_cnt + 1'b1;
          for (int i = 0; i < 4; i++)
            if (is_busy[i] && rem[i] != '0) begin
              rem[i] <= rem[i] - 1'b1;
              if (rem[i] == LEN_W'(1)) is_busy[i] <= 1'b0;
            end
        end
        default: ;
      endcase
    end
  // dequeue strobes: start only for non-empty new locks, words while length remains
  always_comb begin
    deq_start = '0;
    deq_word  = '0;
    for (int i = 0; i < 4; i++) begin
      deq_start[i] = (state == LOAD) && newl[i] && (pkt_len[i*LEN_W+:LEN_W] != '0);
      deq_word[i]  = (state == XFER) && is_busy[i] && (rem[i] != '0);
    end
  end
  // crossbar configuration mirrors the locks during LOAD/XFER only
  always_comb begin
    xbar_vld = '0;
    xbar_sel = '0;
    if (state == LOAD || state == XFER)
      for (int e = 0; e < 4; e++)
        for (int i = 0; i < 4; i++)
          if (is_busy[i] && busy_voq_num[2*i+:2] == 2'(e)) begin
            xbar_vld[e]       = 1'b1;
            xbar_sel[2*e+:2]  = 2'(i);
          end
  end
endmodule

// File: tb/tb_xbar_slot_ctrl.sv
// tb_xbar_slot_ctrl: directed slot scenarios with a scoreboard of expected strobe/crossbar cycles
module tb_xbar_slot_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, sched_done = 1'b0;
  logic [3:0] sched_grant = '0;
  logic [7:0] sched_sel = '0;
  logic [31:0] pkt_len = '0;
  logic sched_en, timeout_err, conflict_err;
  logic [3:0] is_busy, deq_start, deq_word, xbar_vld;
  logic [7:0] busy_voq_num, xbar_sel;
  int total = 0, bad = 0;
  logic [23:0] exp_q [$];

  xbar_slot_ctrl #(.SLOT_CYCLES(16), .LEN_W(8), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sched_en(sched_en),
    .sched_done(sched_done), .sched_grant(sched_grant), .sched_sel(sched_sel),
    .is_busy(is_busy), .busy_voq_num(busy_voq_num), .pkt_len(pkt_len),
    .deq_start(deq_start), .deq_word(deq_word), .xbar_sel(xbar_sel),
    .xbar_vld(xbar_vld), .timeout_err(timeout_err), .conflict_err(conflict_err)
  );

  always #5 clk = ~clk;

  // monitor: every cycle with a dequeue strobe must match the next expected record
  always @(negedge clk)
    if (rst_n && (deq_start | deq_word) != 4'd0) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL monitor: unexpected cycle got %h", {deq_start, deq_word, is_busy, xbar_vld, xbar_sel});
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        if ({deq_start, deq_word, is_busy, xbar_vld, xbar_sel} !== e) begin
          bad++;
          $display("FAIL monitor: got %h expected %h (start,word,busy,vld,sel)",
                   {deq_start, deq_word, is_busy, xbar_vld, xbar_sel}, e);
        end
      end
    end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int n, input logic [3:0] st, input logic [3:0] wd,
                      input logic [3:0] bz, input logic [3:0] vl, input logic [7:0] sl);
    repeat (n) exp_q.push_back({st, wd, bz, vl, sl});
  endtask

  task automatic wait_sched(input int limit);
    int k;
    k = 0;
    @(posedge clk); #1;
    while (!sched_en && k < limit) begin
      @(posedge clk); #1;
      k++;
    end
    if (!sched_en) begin
      total++;
      bad++;
      $display("FAIL wait_sched: sched_en not seen within %0d cycles", limit);
    end
  endtask

  // entered in the SCHED cycle; returns #1 into the LOAD cycle
  task automatic decide(input logic [3:0] g, input logic [7:0] s, input logic [31:0] l);
    @(posedge clk); #1;
    sched_done = 1'b1;
    sched_grant = g;
    sched_sel = s;
    pkt_len = l;
    @(posedge clk); #1;
    sched_done = 1'b0;
    sched_grant = '0;
  endtask

  function automatic logic [34:0] all_out();
    return {sched_en, is_busy, busy_voq_num, deq_start, deq_word, xbar_sel, xbar_vld, timeout_err, conflict_err};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs", all_out(), 0);
    rst_n = 1'b1;
    @(posedge clk); #1 chk("idle_outputs", all_out(), 0);
    enable = 1'b1;
    // A: ingress0 -> egress2, 3 words
    wait_sched(20);
    push(1, 4'b0001, 4'b0000, 4'b0001, 4'b0100, 8'h00);
    push(3, 4'b0000, 4'b0001, 4'b0001, 4'b0100, 8'h00);
    decide(4'b0001, 8'h02, 32'h0000_0003);
    // B: ingress1 -> egress3, 40 words spanning three slots
    wait_sched(40);
    chk("a_busy_cleared", is_busy, 4'b0000);
    chk("a_no_conflict", conflict_err, 1'b0);
    push(1, 4'b0010, 4'b0000, 4'b0010, 4'b1000, 8'h40);
    push(16, 4'b0000, 4'b0010, 4'b0010, 4'b1000, 8'h40);
    decide(4'b0010, 8'h0C, 32'h0000_2800);
    // C: ingress1 regrant ignored, ingress0/2 collide on egress1, ingress0 wins with 5 words
    wait_sched(40);
    chk("b_busy_held", is_busy, 4'b0010);
    push(1, 4'b0001, 4'b0000, 4'b0011, 4'b1010, 8'h40);
    push(5, 4'b0000, 4'b0011, 4'b0011, 4'b1010, 8'h40);
    push(11, 4'b0000, 4'b0010, 4'b0010, 4'b1000, 8'h40);
    decide(4'b0111, 8'h11, 32'h0000_0005);
    // D: scheduler silent, ingress1 drains its last 8 words
    wait_sched(40);
    chk("c_conflict", conflict_err, 1'b1);
    chk("c_no_timeout", timeout_err, 1'b0);
    chk("c_busy", is_busy, 4'b0010);
    chk("c_voq1_kept", busy_voq_num[3:2], 2'd3);
    push(8, 4'b0000, 4'b0010, 4'b0010, 4'b1000, 8'h40);
    // E: ingress2 -> egress0, 30 words, enable dropped mid-slot
    wait_sched(60);
    chk("d_timeout", timeout_err, 1'b1);
    chk("d_busy_cleared", is_busy, 4'b0000);
    push(1, 4'b0100, 4'b0000, 4'b0100, 4'b0001, 8'h02);
    push(16, 4'b0000, 4'b0100, 4'b0100, 4'b0001, 8'h02);
    decide(4'b0100, 8'h00, 32'h001E_0000);
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1 enable = 1'b0;
    n = 0;
    repeat (30) begin
      @(posedge clk); #1;
      n += int'(sched_en);
    end
    chk("e_idle_no_sched", n, 0);
    chk("e_idle_busy_held", is_busy, 4'b0100);
    chk("e_idle_no_words", deq_word, 4'b0000);
    enable = 1'b1;
    wait_sched(10);
    push(14, 4'b0000, 4'b0100, 4'b0100, 4'b0001, 8'h02);
    decide(4'b0000, 8'h00, 32'h0000_0000);
    // F: async reset in the middle of a transfer
    wait_sched(40);
    chk("e_busy_cleared", is_busy, 4'b0000);
    push(1, 4'b0001, 4'b0000, 4'b0001, 4'b1000, 8'h00);
    push(4, 4'b0000, 4'b0001, 4'b0001, 4'b1000, 8'h00);
    decide(4'b0001, 8'h03, 32'h0000_0014);
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("f_async_reset_outputs", all_out(), 0);
    enable = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("f_after_reset_busy", is_busy, 4'b0000);
    chk("f_after_reset_idle", sched_en, 1'b0);
    repeat (3) @(posedge clk);
    #1 chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/xbar_slot_ctrl.md
Name: xbar_slot_ctrl

Overview:
- Time-slot sequencer for the 4x4 VOQ crossbar switch; sits between the crossbar scheduler, the four ingress VOQ blocks and the crossbar datapath.
- Each slot it pulses the scheduler, collects its grant, and locks each granted ingress to its egress until the whole packet has moved.
- Drives per-ingress busy/locked-VOQ state back to the scheduler.
- Issues word-dequeue strobes to the ingress blocks and configures the crossbar egress selects.

Parameters:
SLOT_CYCLES, 16, XFER cycles per slot (>=2)
LEN_W, 8, packet length counter width, in words
TIMEOUT, 8, max WAIT cycles before abandoning a scheduler decision

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  run slots when high
sched_en  out  1  one-cycle pulse that starts a scheduler pass
sched_done  in  1  one-cycle pulse: sched_grant/sched_sel valid
sched_grant  in  4  per-ingress grant
sched_sel  in  8  per-ingress granted VOQ (egress), 2 bits each, ingress i at [2i+1:2i]
is_busy  out  4  ingress i mid-packet
busy_voq_num  out  8  locked egress per ingress, 2 bits each
pkt_len  in  4*LEN_W  head packet length of VOQ busy_voq_num[i], valid during LOAD
deq_start  out  4  pulse: ingress i begins packet on VOQ busy_voq_num[i]
deq_word  out  4  per-ingress one-word dequeue strobe
xbar_sel  out  8  per egress e, source ingress at [2e+1:2e]
xbar_vld  out  4  egress e connected
timeout_err  out  1  sticky: WAIT timed out
conflict_err  out  1  sticky: colliding egress grant dropped

Behaviour:
- Reset (async, rst_n low):
  - state IDLE; all outputs 0.
  - Remaining-length counters rem[i], slot counter and wait counter cleared.
  - Reset mid-packet discards all locks.
- States: IDLE -> SCHED -> WAIT -> LOAD -> XFER -> (SCHED if enable, else IDLE).
- IDLE:
  - No strobes.
  - rem/is_busy held (paused packets resume later).
  - enable high -> SCHED.
- SCHED: sched_en=1 for exactly 1 cycle; wait counter cleared -> WAIT.
- WAIT:
  - sched_done seen -> evaluate grants in ingress order 0..3.
  - Grant to an already-busy ingress: ignored; the lock is kept.
  - Grant to an idle ingress i with egress e:
    - e already held by a busy ingress or by an earlier new grant -> drop the grant, set conflict_err.
    - Otherwise set is_busy[i] and busy_voq_num[i]=e (registered).
  - Then go to LOAD.
  - If TIMEOUT cycles pass without sched_done -> set timeout_err, go to LOAD with no new grants.
  - sched_done while not in WAIT: ignored.
- LOAD (1 cycle):
  - deq_start[i]=1 for each ingress newly locked this slot.
  - At end of cycle rem[i] <= pkt_len[i] for those ingresses.
  - pkt_len[i]==0 -> clear is_busy[i] instead (empty grant, no dequeue).
- XFER (SLOT_CYCLES cycles, slot counter 0..SLOT_CYCLES-1):
  - Each cycle, for every i with is_busy[i] and rem[i]>0: deq_word[i]=1, rem[i]--.
  - On the edge where rem[i] goes 1->0, is_busy[i] clears.
  - The egress is free from the next SCHED.
  - Packets longer than the remaining slot stay busy across slots; rem carries over.
- xbar_vld/xbar_sel:
  - xbar_vld[e]=1 and xbar_sel[e]=i while ingress i is busy on egress e, in LOAD and XFER only.
  - Otherwise xbar_vld=0 and xbar_sel=0.
- Arithmetic:
  - rem is LEN_W bits, unsigned, decrement only, never underflows.
  - Slot counter wraps to 0 at SLOT_CYCLES-1.
- enable low:
  - Sampled only at the end of XFER; the current slot always completes.
  - enable dropped during SCHED/WAIT/LOAD has no effect until XFER ends.
- Invariant: no two busy ingresses hold the same egress.
- Sticky errors clear only on reset.

Test Plan:
- Reset, enable=1, sched_done one cycle after sched_en, grant=4'b0001, sel[1:0]=2, pkt_len[0]=3:
  - deq_start[0] 1 cycle.
  - deq_word[0] in XFER cycles 0-2.
  - is_busy[0] low after cycle 2.
  - xbar_vld[2]=1 with xbar_sel[5:4]=0 during LOAD/XFER.
- pkt_len[1]=40, SLOT_CYCLES=16:
  - is_busy[1] spans 3 slots: 16+16+8 words.
  - Next-slot grants to ingress 1 are ignored.
  - No extra deq_start.
- Grants ingress0->egress1 and ingress2->egress1 in the same decision: ingress 2 dropped, conflict_err=1, only ingress 0 locked.
- sched_done withheld for TIMEOUT cycles: timeout_err=1, FSM reaches XFER, existing busy ingress keeps dequeuing.
- enable dropped mid-XFER:
  - Slot finishes, then IDLE.
  - rem of a 30-word packet holds at 14.
  - Re-enable: resumes with 14 words.
- rst_n low mid-XFER: all outputs 0 immediately (async); after release, IDLE with is_busy=0.
